// File: rtl/noise_reg_interface.sv
// noise_reg_interface: CPU register decode, control fields, strobes and status read for the APU noise channel
module noise_reg_interface #(
  parameter logic [15:0] BASE_ADDR = 16'h400C,
  parameter logic [15:0] STATUS_ADDR = 16'h4015,
  parameter int ENABLE_BIT = 3
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  input  logic        re,
  input  logic        length_non_zero,
  output logic [7:0]  data_out,
  output logic [3:0]  vol,
  output logic        const_vol,
  output logic        length_halt,
  output logic [3:0]  timer_period_in,
  output logic        mode,
  output logic [4:0]  length_load_data,
  output logic        length_load,
  output logic        env_load,
  output logic        disable_l
);
  logic wr_ctl, wr_per, wr_len, wr_st, rd_st;
  logic [7:0] rd_val;
  always_comb begin
    wr_ctl = we && addr == BASE_ADDR;
    wr_per = we && addr == BASE_ADDR + 16'd2;
    wr_len = we && addr == BASE_ADDR + 16'd3;
    wr_st  = we && addr == STATUS_ADDR;
    rd_st  = re && addr == STATUS_ADDR;
    rd_val = rd_st ? 8'(length_non_zero) << ENABLE_BIT : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      data_out         <= 8'h00;
      vol              <= 4'h0;
      const_vol        <= 1'b0;
      length_halt      <= 1'b0;
      timer_period_in  <= 4'h0;
      mode             <= 1'b0;
      length_load_data <= 5'h00;
      length_load      <= 1'b0;
      env_load         <= 1'b0;
      disable_l        <= 1'b0;
    end else if (cpu_clk_en) begin
      data_out    <= rd_val;
      length_load <= wr_len;
      env_load    <= wr_len;
      if (wr_ctl) {length_halt, const_vol, vol} <= data_in[5:0];
      if (wr_per) {mode, timer_period_in} <= {data_in[7], data_in[3:0]};
      if (wr_len) length_load_data <= data_in[7:3];
      if (wr_st) disable_l <= data_in[ENABLE_BIT];
    end
endmodule

// File: tb/tb_noise_reg_interface.sv
// tb_noise_reg_interface: randomized and directed check of noise_reg_interface against a register-file model
module tb_noise_reg_interface;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cpu_clk_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        length_non_zero = 1'b0;
  logic [7:0]  data_out;
  logic [3:0]  vol;
  logic        const_vol;
  logic        length_halt;
  logic [3:0]  timer_period_in;
  logic        mode;
  logic [4:0]  length_load_data;
  logic        length_load;
  logic        env_load;
  logic        disable_l;
  int total = 0;
  int bad = 0;
  int hi_cnt = 0;

  noise_reg_interface dut (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(cpu_clk_en), .addr(addr), .data_in(data_in),
    .we(we), .re(re), .length_non_zero(length_non_zero), .data_out(data_out), .vol(vol),
    .const_vol(const_vol), .length_halt(length_halt), .timer_period_in(timer_period_in),
    .mode(mode), .length_load_data(length_load_data), .length_load(length_load),
    .env_load(env_load), .disable_l(disable_l)
  );

  always #5 clk = ~clk;

  logic [7:0] m_reg [4];
  logic       m_en;
  logic       m_strobe;
  logic [7:0] m_rd;

  always @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_en = 1'b0;
      m_strobe = 1'b0;
      m_rd = 8'h00;
    end else if (cpu_clk_en) begin
      m_rd = (re && addr == 16'h4015 && length_non_zero) ? 8'h08 : 8'h00;
      m_strobe = we && addr == 16'h400F;
      if (we && addr >= 16'h400C && addr <= 16'h400F) m_reg[int'(addr - 16'h400C)] = data_in;
      if (we && addr == 16'h4015) m_en = data_in[3];
    end

  logic [26:0] exp_v, act_v;
  always_comb begin
    exp_v = {m_reg[0][3:0], m_reg[0][4], m_reg[0][5], m_reg[2][3:0], m_reg[2][7], m_reg[3][7:3],
             m_strobe, m_strobe, m_en, m_rd};
    act_v = {vol, const_vol, length_halt, timer_period_in, mode, length_load_data,
             length_load, env_load, disable_l, data_out};
  end

  always @(negedge clk) begin
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model_cycle t=%0t got=%h want=%h", $time, act_v, exp_v);
    end
    hi_cnt += int'(length_load);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input logic en, input logic w, input logic r, input logic [15:0] a,
                      input logic [7:0] d, input logic lnz);
    @(posedge clk);
    #2;
    cpu_clk_en = en; we = w; re = r; addr = a; data_in = d; length_non_zero = lnz;
  endtask

  task automatic op3(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d,
                     input logic lnz);
    tick(1'b1, w, r, a, d, lnz);
    tick(1'b0, w, r, a, d, lnz);
    tick(1'b0, w, r, a, d, lnz);
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {5'h0, act_v}, 32'h0);
    #1 rst_l = 1'b1;
    repeat (10) op3(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    settle();
    chk("idle_outputs", {5'h0, act_v}, 32'h0);
    op3(1'b1, 1'b0, 16'h400C, 8'h3A, 1'b0);
    op3(1'b1, 1'b0, 16'h400E, 8'h85, 1'b0);
    op3(1'b1, 1'b0, 16'h400D, 8'hFF, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    settle();
    chk("fields_400c_400e", {vol, const_vol, length_halt, mode, timer_period_in}, {20'h0, 4'hA, 3'b111, 4'h5});
    hi_cnt = 0;
    op3(1'b1, 1'b0, 16'h400F, 8'hF8, 1'b0);
    op3(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    op3(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    chk("length_load_data", length_load_data, 32'h1F);
    chk("strobe_single_clks", hi_cnt, 32'd3);
    chk("strobe_cleared", {length_load, env_load}, 32'h0);
    hi_cnt = 0;
    op3(1'b1, 1'b0, 16'h400F, 8'h48, 1'b0);
    op3(1'b1, 1'b0, 16'h400F, 8'h50, 1'b0);
    op3(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    op3(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    chk("strobe_back_to_back_clks", hi_cnt, 32'd6);
    chk("length_load_data_b2b", length_load_data, 32'h0A);
    op3(1'b1, 1'b0, 16'h4015, 8'h08, 1'b0);
    settle();
    chk("enable_set", disable_l, 32'h1);
    op3(1'b1, 1'b0, 16'h4015, 8'hF7, 1'b0);
    settle();
    chk("enable_clear", disable_l, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 16'h4015, 8'h08, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    settle();
    chk("we_without_en", disable_l, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 16'h4015, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    #4;
    chk("read_status_one", data_out, 32'h08);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    #4;
    chk("read_cleared", data_out, 32'h00);
    op3(1'b0, 1'b1, 16'h4015, 8'h00, 1'b0);
    settle();
    chk("read_status_zero", data_out, 32'h00);
    op3(1'b1, 1'b1, 16'h4015, 8'h08, 1'b1);
    settle();
    chk("we_re_same_edge", {disable_l, data_out}, 32'h108);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 6))
        0: a = 16'h400C;
        1: a = 16'h400D;
        2: a = 16'h400E;
        3: a = 16'h400F;
        4, 5: a = 16'h4015;
        default: a = 16'($urandom);
      endcase
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
           8'($urandom), 1'($urandom_range(0, 1)));
    end
    op3(1'b1, 1'b0, 16'h400C, 8'h3F, 1'b0);
    op3(1'b1, 1'b0, 16'h400F, 8'hF8, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("strobe_before_reset", {length_load, env_load}, 32'h3);
    rst_l = 1'b0;
    #1;
    chk("async_reset_clears", {5'h0, act_v}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    settle();
    chk("after_reset", {5'h0, act_v}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
